// File: rtl/switch_scheduler_pkg.sv
// Shared types for the 4-port switch output scheduler: port ids/masks, FSM states, packet types.
package switch_scheduler_pkg;

  localparam int unsigned NUM_PORTS = 4;

  typedef logic [1:0] port_id_t;
  typedef logic [3:0] port_mask_t;

  typedef enum logic [1:0] {
    StIdle,
    StRoute,
    StArbWait,
    StTransmit
  } port_state_e;

  typedef enum logic [1:0] {
    PtErr = 2'd0,
    PtSdp = 2'd1,
    PtMdp = 2'd2,
    PtBdp = 2'd3
  } p_type_e;

  function automatic logic [2:0] popcount4(port_mask_t m);
    logic [2:0] c;
    c = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      c = c + {2'b00, m[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/switch_scheduler_port_fsm.sv
// Per-input request FSM: header latch, target-mask validation, wait counter and urgency flag.
module sched_port_fsm
  import switch_scheduler_pkg::*;
#(
  parameter port_id_t    PortIdx = 2'd0,
  parameter int unsigned MaxWait = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req_i,
  input  port_mask_t dst_i,
  input  logic [1:0] type_i,
  input  logic       eop_i,
  input  logic       win_i,
  output logic       arb_o,
  output logic       urgent_o,
  output logic       grant_o,
  output logic       drop_o,
  output port_mask_t target_o
);

  localparam int unsigned CntW = $clog2(MaxWait + 1);

  port_state_e state_q, state_d;
  port_mask_t  dst_q, dst_d;
  p_type_e     type_q, type_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  port_mask_t own_mask;
  logic       valid;
  logic [2:0] pop;

  assign own_mask = port_mask_t'(1) << PortIdx;
  assign pop      = popcount4(dst_q);

  always_comb begin
    target_o = dst_q;
    valid    = 1'b0;
    unique case (type_q)
      PtSdp:   valid = (pop == 3'd1) && ((dst_q & own_mask) == '0);
      PtMdp:   valid = (pop >= 3'd2) && ((dst_q & own_mask) == '0);
      PtBdp: begin
        target_o = ~own_mask;
        valid    = 1'b1;
      end
      default: valid = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    dst_d   = dst_q;
    type_d  = type_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req_i) begin
          dst_d   = dst_i;
          type_d  = p_type_e'(type_i);
          state_d = StRoute;
        end
      end
      StRoute: begin
        if (valid) begin
          cnt_d   = '0;
          state_d = StArbWait;
        end else begin
          state_d = StIdle;
        end
      end
      StArbWait: begin
        if (win_i) begin
          state_d = StTransmit;
        end else if (cnt_q != CntW'(MaxWait)) begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StTransmit: begin
        if (eop_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign arb_o    = (state_q == StArbWait);
  assign urgent_o = arb_o && (cnt_q == CntW'(MaxWait));
  assign grant_o  = (state_q == StTransmit);
  assign drop_o   = (state_q == StRoute) && !valid;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      dst_q   <= '0;
      type_q  <= PtErr;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dst_q   <= dst_d;
      type_q  <= type_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/switch_scheduler.sv
// Output-port scheduler: rotating all-or-nothing allocation with aging, held until end-of-packet.
module switch_scheduler
  import switch_scheduler_pkg::*;
#(
  parameter int unsigned MaxWait = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [3:0]  in_req_i,
  input  logic [15:0] in_dst_i,
  input  logic [7:0]  in_type_i,
  input  logic [3:0]  in_eop_i,
  output logic [3:0]  in_grant_o,
  output logic [3:0]  in_drop_o,
  output logic [3:0]  out_busy_o,
  output logic [7:0]  out_src_o
);

  port_mask_t [NUM_PORTS-1:0] target;
  logic [NUM_PORTS-1:0] arb, urgent, win;

  port_id_t   rr_ptr_q, rr_ptr_d;
  port_mask_t out_busy_q, out_busy_d;
  logic [7:0] out_src_q, out_src_d;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    sched_port_fsm #(
      .PortIdx (port_id_t'(i)),
      .MaxWait (MaxWait)
    ) u_port (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .req_i    (in_req_i[i]),
      .dst_i    (in_dst_i[4*i +: 4]),
      .type_i   (in_type_i[2*i +: 2]),
      .eop_i    (in_eop_i[i]),
      .win_i    (win[i]),
      .arb_o    (arb[i]),
      .urgent_o (urgent[i]),
      .grant_o  (in_grant_o[i]),
      .drop_o   (in_drop_o[i]),
      .target_o (target[i])
    );
  end

  // Scan from rr_ptr; an urgent loser reserves its outputs against later inputs in the scan.
  always_comb begin
    port_mask_t claimed, blocked;
    port_id_t   idx, last;
    logic       any_win;
    claimed = '0;
    blocked = '0;
    idx     = '0;
    last    = '0;
    any_win = 1'b0;
    win     = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = rr_ptr_q + port_id_t'(k);
      if (arb[idx]) begin
        if ((target[idx] & (out_busy_q | claimed | blocked)) == '0) begin
          win[idx] = 1'b1;
          claimed  = claimed | target[idx];
          last     = idx;
          any_win  = 1'b1;
        end else if (urgent[idx]) begin
          blocked = blocked | target[idx];
        end
      end
    end
    rr_ptr_d = any_win ? last + 2'd1 : rr_ptr_q;
  end

  always_comb begin
    out_busy_d = out_busy_q;
    out_src_d  = out_src_q;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (in_grant_o[i] && in_eop_i[i]) begin
        for (int o = 0; o < NUM_PORTS; o++) begin
          if (target[i][o]) begin
            out_busy_d[o]       = 1'b0;
            out_src_d[2*o +: 2] = '0;
          end
        end
      end
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (win[i]) begin
        for (int o = 0; o < NUM_PORTS; o++) begin
          if (target[i][o]) begin
            out_busy_d[o]       = 1'b1;
            out_src_d[2*o +: 2] = port_id_t'(i);
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q   <= '0;
      out_busy_q <= '0;
      out_src_q  <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      out_busy_q <= out_busy_d;
      out_src_q  <= out_src_d;
    end
  end

  assign out_busy_o = out_busy_q;
  assign out_src_o  = out_src_q;

endmodule
